// File: rtl/phy_rx_align.sv
// phy_rx_align: bit-clock serial-to-parallel receiver with comma alignment, sync lock and symbol strobe.
// Optional feature macro RX_REALIGN_EN: re-aligns on a mid-symbol comma while locked.
module phy_rx_align #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = 8'hBC,
    parameter int SYNC_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             sym_strobe,
    output logic             active,
    output logic             realign
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(SYNC_COUNT + 1);
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr, s, data_n;
    logic [BW-1:0] bitcnt, bitcnt_n, bitcnt_inc;
    logic [CW-1:0] ccount, ccount_n;
    logic valid_n, strobe_n, active_n, boundary, is_comma;
    assign s = {sr[WIDTH-2:0], data_in};
    assign is_comma = s == COMMA;
    assign boundary = bitcnt == BW'(WIDTH - 1);
    assign bitcnt_inc = boundary ? '0 : bitcnt + 1'b1;
`ifdef RX_REALIGN_EN
    logic realign_n;
    always_ff @(posedge clk_32f)
        realign <= reset ? 1'b0 : realign_n;
`else
    assign realign = 1'b0;
`endif
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= HUNT;
            sr         <= '0;
            bitcnt     <= '0;
            ccount     <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            sym_strobe <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= s;
            bitcnt     <= bitcnt_n;
            ccount     <= ccount_n;
            data_out   <= data_n;
            valid_out  <= valid_n;
            sym_strobe <= strobe_n;
            active     <= active_n;
        end
    end
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        ccount_n = ccount;
        data_n   = data_out;
        valid_n  = valid_out;
        strobe_n = 1'b0;
        active_n = active;
`ifdef RX_REALIGN_EN
        realign_n = 1'b0;
`endif
        case (state)
            HUNT: begin
                if (is_comma) begin
                    bitcnt_n = '0;
                    ccount_n = CW'(1);
                    state_n  = (SYNC_COUNT == 1) ? LOCKED : SYNC;
                    active_n = SYNC_COUNT == 1;
                end
            end
            SYNC: begin
                bitcnt_n = bitcnt_inc;
                if (boundary && is_comma) begin
                    ccount_n = ccount + 1'b1;
                    if (int'(ccount) + 1 == SYNC_COUNT) begin
                        state_n  = LOCKED;
                        active_n = 1'b1;
                    end
                end else if (boundary) begin
                    state_n  = HUNT;
                    ccount_n = '0;
                end
            end
            LOCKED: begin
                bitcnt_n = bitcnt_inc;
                strobe_n = boundary;
                if (boundary) begin
                    valid_n = !is_comma;
                    data_n  = is_comma ? data_out : s;
                end
`ifdef RX_REALIGN_EN
                else if (is_comma) begin
                    bitcnt_n  = '0;
                    realign_n = 1'b1;
                end
`endif
            end
            default: state_n = HUNT;
        endcase
    end
endmodule

// File: tb/tb_phy_rx_align.sv
// tb_phy_rx_align: directed vectors for phy_rx_align, default build plus a WIDTH=10 instance.
module tb_phy_rx_align;
    logic clk_32f = 1'b0;
    logic reset, data_in, reset2, data_in2;
    logic [7:0] data_out;
    logic [9:0] data_out2;
    logic valid_out, sym_strobe, active, realign;
    logic valid_out2, sym_strobe2, active2, realign2;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk_32f = ~clk_32f;

    phy_rx_align dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .data_out(data_out),
        .valid_out(valid_out), .sym_strobe(sym_strobe), .active(active), .realign(realign)
    );

    phy_rx_align #(.WIDTH(10), .COMMA(10'h17C), .SYNC_COUNT(1)) dut10 (
        .clk_32f(clk_32f), .reset(reset2), .data_in(data_in2), .data_out(data_out2),
        .valid_out(valid_out2), .sym_strobe(sym_strobe2), .active(active2), .realign(realign2)
    );

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send8(input logic [7:0] v, output logic [7:0] sp, output logic [7:0] ap, output logic [7:0] rp);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[7-i]);
            sp[7-i] = sym_strobe;
            ap[7-i] = active;
            rp[7-i] = realign;
        end
    endtask

    task automatic send10(input logic [9:0] v, output logic [9:0] sp, output logic [9:0] ap);
        for (int i = 0; i < 10; i++) begin
            data_in2 = v[9-i];
            @(posedge clk_32f);
            #1;
            sp[9-i] = sym_strobe2;
            ap[9-i] = active2;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock4;
        logic [7:0] sp, ap, rp;
        repeat (4) send8(8'hBC, sp, ap, rp);
    endtask

    task automatic test_reset;
        reset = 1'b1; reset2 = 1'b1; data_in = 1'b1; data_in2 = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        vectors++; if ({data_out, valid_out, sym_strobe, active, realign} !== 12'h000) begin miscompares++; $display("FAIL reset_w8 got %h exp 000", {data_out, valid_out, sym_strobe, active, realign}); end
        vectors++; if ({data_out2, valid_out2, sym_strobe2, active2, realign2} !== 14'h0000) begin miscompares++; $display("FAIL reset_w10 got %h exp 0000", {data_out2, valid_out2, sym_strobe2, active2, realign2}); end
    endtask

    task automatic test_lock;
        logic [7:0] sp, ap, rp;
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL lock_pre got %b exp 0", active); end
        for (int k = 0; k < 3; k++) begin
            send8(8'hBC, sp, ap, rp);
            vectors++; if (ap !== 8'h00) begin miscompares++; $display("FAIL lock_comma%0d active got %h exp 00", k, ap); end
        end
        send8(8'hBC, sp, ap, rp);
        vectors++; if (ap !== 8'h01) begin miscompares++; $display("FAIL lock_comma4 active got %h exp 01", ap); end
        vectors++; if (sp !== 8'h00) begin miscompares++; $display("FAIL lock_strobe got %h exp 00", sp); end
        vectors++; if ({data_out, valid_out} !== 9'h000) begin miscompares++; $display("FAIL lock_out got %h exp 000", {data_out, valid_out}); end
    endtask

    task automatic test_data;
        logic [7:0] sp, ap, rp;
        send8(8'h5A, sp, ap, rp);
        vectors++; if (sp !== 8'h01) begin miscompares++; $display("FAIL data_5a_strobe got %h exp 01", sp); end
        vectors++; if ({data_out, valid_out} !== {8'h5A, 1'b1}) begin miscompares++; $display("FAIL data_5a got %h/%b exp 5a/1", data_out, valid_out); end
        send8(8'hBC, sp, ap, rp);
        vectors++; if (sp !== 8'h01) begin miscompares++; $display("FAIL data_bc_strobe got %h exp 01", sp); end
        vectors++; if ({data_out, valid_out} !== {8'h5A, 1'b0}) begin miscompares++; $display("FAIL data_bc got %h/%b exp 5a/0", data_out, valid_out); end
        send8(8'hC3, sp, ap, rp);
        vectors++; if (sp !== 8'h01) begin miscompares++; $display("FAIL data_c3_strobe got %h exp 01", sp); end
        vectors++; if ({data_out, valid_out} !== {8'hC3, 1'b1}) begin miscompares++; $display("FAIL data_c3 got %h/%b exp c3/1", data_out, valid_out); end
        vectors++; if (ap !== 8'hFF) begin miscompares++; $display("FAIL data_active got %h exp ff", ap); end
    endtask

    task automatic test_sync_break;
        logic [7:0] sp, ap, rp;
        do_reset();
        send8(8'hBC, sp, ap, rp);
        send8(8'hBC, sp, ap, rp);
        send8(8'h00, sp, ap, rp);
        vectors++; if (ap !== 8'h00) begin miscompares++; $display("FAIL break_00 active got %h exp 00", ap); end
        for (int k = 0; k < 3; k++) begin
            send8(8'hBC, sp, ap, rp);
            vectors++; if (ap !== 8'h00) begin miscompares++; $display("FAIL break_comma%0d active got %h exp 00", k, ap); end
        end
        send8(8'hBC, sp, ap, rp);
        vectors++; if (ap !== 8'h01) begin miscompares++; $display("FAIL break_lock active got %h exp 01", ap); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] sp, ap, rp;
        send8(8'h5A, sp, ap, rp);
        vectors++; if ({data_out, valid_out} !== {8'h5A, 1'b1}) begin miscompares++; $display("FAIL mid_pre got %h/%b exp 5a/1", data_out, valid_out); end
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        vectors++; if ({data_out, valid_out, sym_strobe, active, realign} !== 12'h000) begin miscompares++; $display("FAIL mid_reset got %h exp 000", {data_out, valid_out, sym_strobe, active, realign}); end
        for (int k = 0; k < 3; k++) send8(8'hBC, sp, ap, rp);
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL mid_relock3 got %b exp 0", active); end
        send8(8'hBC, sp, ap, rp);
        vectors++; if (ap !== 8'h01) begin miscompares++; $display("FAIL mid_relock4 active got %h exp 01", ap); end
    endtask

    task automatic test_param;
        logic [9:0] sp, ap;
        reset2 = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        reset2 = 1'b0;
        send10(10'h17C, sp, ap);
        vectors++; if (ap !== 10'h001) begin miscompares++; $display("FAIL w10_lock active got %h exp 001", ap); end
        vectors++; if (sp !== 10'h000) begin miscompares++; $display("FAIL w10_lock_strobe got %h exp 000", sp); end
        send10(10'h2A5, sp, ap);
        vectors++; if (sp !== 10'h001) begin miscompares++; $display("FAIL w10_2a5_strobe got %h exp 001", sp); end
        vectors++; if ({data_out2, valid_out2} !== {10'h2A5, 1'b1}) begin miscompares++; $display("FAIL w10_2a5 got %h/%b exp 2a5/1", data_out2, valid_out2); end
        send10(10'h0F3, sp, ap);
        vectors++; if (sp !== 10'h001) begin miscompares++; $display("FAIL w10_0f3_strobe got %h exp 001", sp); end
        vectors++; if ({data_out2, valid_out2} !== {10'h0F3, 1'b1}) begin miscompares++; $display("FAIL w10_0f3 got %h/%b exp 0f3/1", data_out2, valid_out2); end
    endtask

    task automatic test_realign;
        logic [7:0] sp, ap, rp, exp_rp, exp_sp, exp_d;
`ifdef RX_REALIGN_EN
        exp_rp = 8'h01; exp_sp = 8'h01; exp_d = 8'h7E;
`else
        exp_rp = 8'h00; exp_sp = 8'h08; exp_d = 8'h8F;
`endif
        do_reset();
        lock4();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send8(8'hBC, sp, ap, rp);
        vectors++; if (sp !== 8'h08) begin miscompares++; $display("FAIL realign_comma_strobe got %h exp 08", sp); end
        vectors++; if (rp !== exp_rp) begin miscompares++; $display("FAIL realign_pulse got %h exp %h", rp, exp_rp); end
        vectors++; if ({data_out, valid_out} !== {8'hB7, 1'b1}) begin miscompares++; $display("FAIL realign_hold got %h/%b exp b7/1", data_out, valid_out); end
        send8(8'h7E, sp, ap, rp);
        vectors++; if (sp !== exp_sp) begin miscompares++; $display("FAIL realign_7e_strobe got %h exp %h", sp, exp_sp); end
        vectors++; if ({data_out, valid_out} !== {exp_d, 1'b1}) begin miscompares++; $display("FAIL realign_7e got %h/%b exp %h/1", data_out, valid_out, exp_d); end
        vectors++; if ({ap, rp} !== 16'hFF00) begin miscompares++; $display("FAIL realign_after got %h exp ff00", {ap, rp}); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data();
        test_sync_break();
        test_reset_mid();
        test_param();
        test_realign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/phy_rx_align.md
Name: phy_rx_align

Overview:
- Parametrised successor to the PHY receive path: single-lane serial-to-parallel converter with comma-based symbol alignment and sync lock.
- Runs entirely on the bit clock. Replaces divided-clock output with a symbol strobe, so the symbol width is free.
- Sits after the serial lane and before the byte un-striper. Its outputs feed the un-striper's data/valid inputs.

Parameters:
- WIDTH, 8, symbol width in bits (>=4). The serial stream is MSB first.
- COMMA, 8'hBC, idle/alignment symbol. Width WIDTH.
- SYNC_COUNT, 4, consecutive aligned commas required to assert active (>=1).

Ports:
- clk_32f  input  1  bit clock. All logic is on its rising edge.
- reset  input  1  synchronous, active-high. Clears all state.
- data_in  input  1  serial bit, sampled every edge.
- data_out  output  WIDTH  last non-comma symbol received.
- valid_out  output  1  level; 1 while the most recent symbol was data, 0 while it was idle (comma).
- sym_strobe  output  1  one-cycle pulse at each symbol boundary while locked.
- active  output  1  lane locked.
- realign  output  1  one-cycle pulse on realignment (RX_REALIGN_EN only; else constant 0).

Behaviour:
- Reset values: data_out=0, valid_out=0, sym_strobe=0, active=0, realign=0. Internal state: sr=0, bitcnt=0, ccount=0, state=HUNT.
- Every edge, s = {sr[WIDTH-2:0], data_in} and sr <= s. All decisions below use s.
- bitcnt width is $clog2(WIDTH). A boundary edge is any edge with bitcnt==WIDTH-1 before the edge.
- HUNT: if s==COMMA, then bitcnt<=0 and ccount<=1. Go to LOCKED with active<=1 if SYNC_COUNT==1, else to SYNC. Otherwise stay in HUNT; bitcnt is unused.
- SYNC: bitcnt <= (bitcnt==WIDTH-1) ? 0 : bitcnt+1. On a boundary edge:
  - s==COMMA: ccount<=ccount+1. If ccount+1==SYNC_COUNT, go to LOCKED and set active<=1 on this edge.
  - s!=COMMA: go to HUNT, ccount<=0.
  - No outputs change in SYNC.
- LOCKED: bitcnt wraps as in SYNC. On a boundary edge, sym_strobe<=1; at all other edges sym_strobe<=0.
  - s!=COMMA: data_out<=s, valid_out<=1.
  - s==COMMA: valid_out<=0, data_out holds.
- Latency: the last bit of a symbol sampled at edge E appears on data_out/valid_out/sym_strobe immediately after E.
- active stays 1 until reset; there is no loss-of-sync exit in the base block.
- A comma pattern straddling a boundary in LOCKED is ignored unless RX_REALIGN_EN is defined.
- Reset asserted mid-symbol or mid-sync: next edge returns to HUNT with all outputs at reset values. Data_in on that edge is discarded.
- Back-to-back: a data symbol immediately after the locking comma is output on its boundary edge with no bubble.

Optional Feature:
- Macro: RX_REALIGN_EN.
- Defined: in LOCKED, a non-boundary edge with s==COMMA forces bitcnt<=0 and pulses realign for one cycle.
  - active stays 1; valid_out and data_out hold; no sym_strobe.
  - The next boundary is WIDTH edges later.
- Undefined: realign is tied to 0, and mid-symbol comma patterns are treated as ordinary bits.

Test Plan:
- Lock: reset 2 cycles, then 3 random bits, then 4x 8'hBC MSB first. active rises on the edge sampling the last bit of the 4th comma, not before; data_out=0, valid_out=0.
- Data: after lock, send 8'h5A, 8'hBC, 8'hC3. sym_strobe pulses every 8 edges; data_out=5A with valid_out=1, then valid_out=0 with data_out=5A held, then data_out=C3 with valid_out=1.
- Sync break: 2x BC, then 8'h00, then 4x BC. No lock after the 00; active rises only after the 4 later commas.
- Reset mid-operation: assert reset in the 5th bit of a data symbol while locked. Next edge: all outputs 0 and state HUNT; re-lock needs 4 fresh commas.
- Parametrised: WIDTH=10, COMMA=10'h17C, SYNC_COUNT=1. active asserts on the first comma; each subsequent 10-bit symbol strobes exactly 10 edges apart.
- RX_REALIGN_EN: while locked, insert 3 extra bits and then 8'hBC. realign pulses once; the following 8'h7E is output correctly 8 edges after the comma completes; active stays 1.
